// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
//   Shared definitions for the LFSR random-byte arbiter:
//     - LFSR width, feedback tap mask and default seed
//     - arbiter FSM state encoding
//     - lfsr_next(): one Fibonacci step of x^8+x^6+x^5+x^4+1
// -----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int LFSR_W = 8;

    // Bits 7,5,4,3 feed the XOR that becomes the new LSB.
    localparam logic [LFSR_W-1:0] TAP_MASK = 8'hB8;

    // Value after reset and the substitute for an illegal all-zero seed.
    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 8'h01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        DELIVER = 2'd2
    } state_e;

    // Shift left, new LSB is the parity of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & TAP_MASK)};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// -----------------------------------------------------------------------------
// lfsr_core
//   8-bit Fibonacci LFSR register with synchronous load and step enables.
//   Holds its value when neither load nor step is asserted.
//
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-high reset (loads SEED)
//   load     in   load load_val this cycle (wins over step)
//   load_val in   8-bit value to load; caller guarantees it is non-zero
//   step     in   advance one LFSR step this cycle
//   q        out  current LFSR value
// -----------------------------------------------------------------------------
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// -----------------------------------------------------------------------------
// lfsr_rng_arbiter
//   Shares one 8-bit LFSR among N_REQ requesters. A round-robin search picks
//   one requester in IDLE, the LFSR then advances STEPS times, and the
//   resulting byte is offered on a valid/ready response channel tagged with
//   the requester index. A seed can be loaded while IDLE; a zero seed is
//   replaced by SEED_DEFAULT and flagged in a sticky error bit.
//
// Handshakes (valid/ready):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   Once rsp_valid rises, rsp_valid/rsp_data/rsp_id/gnt stay stable until
//   that transfer. The seed channel transfers on seed_valid && seed_ready;
//   seed_ready is high only in IDLE, so a seed offered while busy waits.
//
// Ports:
//   clk           in   clock
//   reset         in   asynchronous active-high reset
//   req           in   level request per requester, held until accepted
//   gnt           out  one-hot grant, high from grant until accepted
//   rsp_valid     out  random byte available
//   rsp_ready     in   consumer accepts the byte
//   rsp_data      out  random byte (keeps its value after acceptance)
//   rsp_id        out  index of the granted requester
//   seed_valid    in   seed load request
//   seed_data     in   seed value
//   seed_ready    out  high in IDLE only
//   busy          out  high whenever the FSM is not IDLE
//   zero_seed_err out  sticky flag, set when a zero seed is loaded
//   dbg_state     out  current FSM state encoding (lfsr_pkg::state_e)
// -----------------------------------------------------------------------------
module lfsr_rng_arbiter #(
    parameter int         N_REQ        = 4,
    parameter int         ID_W         = 2,
    parameter int         STEPS        = 4,
    parameter logic [7:0] SEED_DEFAULT = lfsr_pkg::SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic [ID_W-1:0]  rsp_id,
    input  logic             seed_valid,
    input  logic [7:0]       seed_data,
    output logic             seed_ready,
    output logic             busy,
    output logic             zero_seed_err,
    output logic [1:0]       dbg_state
);

    import lfsr_pkg::*;

    // Index arithmetic is done in 4 bits: rr_ptr + offset never exceeds
    // 2*N_REQ-2 = 14 for N_REQ <= 8.
    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;
    logic             err_q, err_d;

    logic             lfsr_load;
    logic             lfsr_step;
    logic [7:0]       lfsr_val;
    logic [7:0]       load_val;

    logic [15:0]      req_ext;
    logic [3:0]       idx;
    logic [3:0]       pick;
    logic             found;
    logic [3:0]       id_inc;

    // ------------------------------------------------------------------
    // LFSR datapath
    // ------------------------------------------------------------------
    assign load_val = (seed_data == 8'h00) ? SEED_DEFAULT : seed_data;

    lfsr_core #(
        .SEED (SEED_DEFAULT)
    ) u_lfsr_core (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_load),
        .load_val (load_val),
        .step     (lfsr_step),
        .q        (lfsr_val)
    );

    // ------------------------------------------------------------------
    // Round-robin search: first set request at or above rr_ptr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        req_ext = 16'(req);
        found   = 1'b0;
        pick    = '0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = 4'(rr_q) + 4'(i);
            if (idx >= 4'(N_REQ)) begin
                idx = idx - 4'(N_REQ);
            end
            if (!found && req_ext[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Pointer after serving rsp_id: one past it, wrapping at N_REQ.
    assign id_inc = 4'(id_q) + 4'd1;

    // ------------------------------------------------------------------
    // FSM next state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        id_d      = id_q;
        gnt_d     = gnt_q;
        valid_d   = valid_q;
        data_d    = data_q;
        err_d     = err_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        case (state_q)
            IDLE: begin
                // A seed wins over a same-cycle request; the request is
                // served next cycle from the freshly loaded seed.
                if (seed_valid) begin
                    lfsr_load = 1'b1;
                    if (seed_data == 8'h00) begin
                        err_d = 1'b1;
                    end
                end else if (found) begin
                    gnt_d   = N_REQ'(16'd1 << pick);
                    id_d    = ID_W'(pick);
                    cnt_d   = 4'(STEPS);
                    state_d = STEP;
                end
            end

            STEP: begin
                lfsr_step = 1'b1;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    // Capture the value the LFSR holds after this last step.
                    valid_d = 1'b1;
                    data_d  = lfsr_next(lfsr_val);
                    state_d = DELIVER;
                end
            end

            DELIVER: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    gnt_d   = '0;
                    rr_d    = (id_inc >= 4'(N_REQ)) ? '0 : ID_W'(id_inc);
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            id_q    <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt           = gnt_q;
    assign rsp_valid     = valid_q;
    assign rsp_data      = data_q;
    assign rsp_id        = id_q;
    assign seed_ready    = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign zero_seed_err = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
module tb_lfsr_rng_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int STEPS = 4;
    localparam int W     = ID_W + 8;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             reset;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;
    logic [ID_W-1:0]  rsp_id;
    logic             seed_valid;
    logic [7:0]       seed_data;
    logic             seed_ready;
    logic             busy;
    logic             zero_seed_err;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    lfsr_rng_arbiter #(
        .N_REQ        (N_REQ),
        .ID_W         (ID_W),
        .STEPS        (STEPS),
        .SEED_DEFAULT (8'h01)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .gnt           (gnt),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_id        (rsp_id),
        .seed_valid    (seed_valid),
        .seed_data     (seed_data),
        .seed_ready    (seed_ready),
        .busy          (busy),
        .zero_seed_err (zero_seed_err),
        .dbg_state     (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int acc_cyc[$];
    int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready

    logic [W-1:0] exp_q[$];

    // Reference model: the whole maximal-length sequence from 01 and a
    // position in it, plus the round-robin pointer and the sticky error.
    logic [7:0] seq[255];
    int         m_pos;
    int         m_rr;
    logic       m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] spec_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic build_seq();
        seq[0] = 8'h01;
        for (int k = 1; k < 255; k++) seq[k] = spec_step(seq[k-1]);
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_rr  = 0;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_seed(input logic [7:0] v);
        if (v == 8'h00) begin
            m_pos = 0;
            m_err = 1'b1;
        end else begin
            for (int k = 0; k < 255; k++) if (seq[k] == v) m_pos = k;
        end
    endtask

    task automatic model_grant(input logic [N_REQ-1:0] mask, output int id);
        int j;
        id = -1;
        for (int i = 0; i < N_REQ; i++) begin
            j = (m_rr + i) % N_REQ;
            if (id < 0 && mask[j]) id = j;
        end
        m_pos = (m_pos + STEPS) % 255;
        exp_q.push_back({ID_W'(id), seq[m_pos]});
        m_rr = (id + 1) % N_REQ;
    endtask

    // ---------------- cycle counter ----------------
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- consumer ready driver ----------------
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 2) != 0);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic             stall;
        logic [7:0]       sd;
        logic [ID_W-1:0]  sid;
        logic [N_REQ-1:0] sg;
        logic [W-1:0]     e;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else if (rsp_valid) begin
                if (stall) begin
                    check("hold_data", rsp_data, sd);
                    check("hold_id", rsp_id, sid);
                    check("hold_gnt", gnt, sg);
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_rsp: got id %0d data %0h, expected no response", rsp_id, rsp_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_id", rsp_id, e[W-1:8]);
                        check("rsp_data", rsp_data, e[7:0]);
                        check("rsp_gnt", gnt, 32'd1 << e[W-1:8]);
                    end
                    n_acc++;
                    acc_cyc.push_back(cyc);
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    sd    = rsp_data;
                    sid   = rsp_id;
                    sg    = gnt;
                end
            end else begin
                stall = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("idle_timeout", busy, 1'b0);
    endtask

    task automatic wait_accept(input int base);
        int t = 0;
        while (n_acc == base && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("accept_seen", (n_acc != base), 1'b1);
    endtask

    task automatic wait_grant(input int id);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (gnt == '0 && t < 10);
        check("grant", gnt, 32'd1 << id);
        check("busy_in_step", busy, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One transaction: optional seed in the same cycle as the request, the
    // request dropped right after grant, optional seed offered while busy.
    task automatic do_txn(input logic [N_REQ-1:0] mask, input bit do_seed,
                          input logic [7:0] seed_v, input bit busy_seed);
        int id;
        int base;
        wait_idle();
        base = n_acc;
        if (do_seed) begin
            seed_valid = 1'b1;
            seed_data  = seed_v;
            model_seed(seed_v);
        end
        req = mask;
        model_grant(mask, id);
        if (do_seed) begin
            @(negedge clk);
            check("seed_cycle_idle", busy, 1'b0);
            seed_valid = 1'b0;
        end
        wait_grant(id);
        req = '0;
        if (busy_seed) begin
            seed_valid = 1'b1;
            seed_data  = 8'($urandom_range(0, 255));
            @(negedge clk);
            check("seed_ready_busy", seed_ready, 1'b0);
            seed_valid = 1'b0;
        end
        wait_accept(base);
        check("zero_seed_err", zero_seed_err, m_err);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int id;
        int base;
        int base_idx;
        int c0;
        int t;

        build_seq();
        model_reset();
        reset      = 1'b1;
        req        = '0;
        seed_valid = 1'b0;
        seed_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_data", rsp_data, 0);
        check("rst_id", rsp_id, 0);
        check("rst_err", zero_seed_err, 0);
        check("rst_seed_ready", seed_ready, 1);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // Basic: two single-requester transactions -> 11 then 1C.
        ready_mode = 0;
        do_txn(4'b0001, 1'b0, 8'h00, 1'b0);
        do_txn(4'b0001, 1'b0, 8'h00, 1'b0);

        // All requesters held: ids 0,1,2,3,0, latency and spacing.
        do_reset();
        @(negedge clk);
        base     = n_acc;
        base_idx = acc_cyc.size();
        c0       = cyc;
        req      = 4'hF;
        for (int k = 0; k < 5; k++) model_grant(4'hF, id);
        t = 0;
        while (n_acc < base + 5 && t < 100) begin
            @(negedge clk);
            t++;
        end
        req = '0;
        check("held_count", n_acc - base, 5);
        if (n_acc >= base + 5) begin
            check("latency", acc_cyc[base_idx] - c0, STEPS + 1);
            for (int k = 1; k < 5; k++)
                check("spacing", acc_cyc[base_idx+k] - acc_cyc[base_idx+k-1], STEPS + 2);
        end

        // Seed 23 together with req 0010 -> seed first, byte 38, id 1.
        do_txn(4'b0010, 1'b1, 8'h23, 1'b0);
        // Zero seed -> substitute 01, sticky error, byte 11.
        do_txn(4'b0001, 1'b1, 8'h00, 1'b1);

        // Back-pressure for 10 cycles in DELIVER; request dropped in STEP.
        wait_idle();
        ready_mode = 2;
        base = n_acc;
        req  = 4'b0100;
        model_grant(4'b0100, id);
        wait_grant(id);
        req = '0;
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        check("stall_valid", rsp_valid, 1'b1);
        ready_mode = 0;
        wait_accept(base);
        do_txn(4'b1000, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset in the third STEP cycle.
        wait_idle();
        req = 4'b0001;
        model_grant(4'b0001, id);
        wait_grant(id);
        repeat (2) @(negedge clk);
        req   = '0;
        reset = 1'b1;
        #1;
        check("arst_gnt", gnt, 0);
        check("arst_valid", rsp_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_id", rsp_id, 0);
        check("arst_data", rsp_data, 0);
        check("arst_err", zero_seed_err, 0);
        check("arst_seed_ready", seed_ready, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        do_txn(4'b0001, 1'b0, 8'h00, 1'b0);

        // Randomized traffic with random back-pressure and seeds.
        ready_mode = 1;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] sv;
            sv = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) sv = 8'h00;
            do_txn(4'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0), sv,
                   ($urandom_range(0, 2) == 0));
        end

        ready_mode = 0;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d accepts", n_acc);
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
